// File: rtl/operand_entry.sv
// operand_entry: captures two operands from a switch bank, one per state,
// and offers the completed pair to a consumer with a valid/ready handshake.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   switch_in[N-1:0]      raw switch value
//   load_btn, next_btn    button levels; each rising edge is one event
//   append_mode           0 = direct load, 1 = shift-append
//   clear                 synchronous clear (priority over all events)
//   out_ready             consumer accepts the pair while out_valid=1
//   operand_a/operand_b   operand registers (W bits)
//   out_valid             pair complete and offered (VALID state only)
//   state_o               00 ENTER_A, 01 ENTER_B, 10 VALID
//   overflow              sticky flag: an append shifted out nonzero bits
module operand_entry #(
  parameter int unsigned N      = 4,
  parameter int unsigned W      = 6,
  parameter int unsigned SIGNED = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] switch_in,
  input  logic         load_btn,
  input  logic         next_btn,
  input  logic         append_mode,
  input  logic         clear,
  input  logic         out_ready,
  output logic [W-1:0] operand_a,
  output logic [W-1:0] operand_b,
  output logic         out_valid,
  output logic [1:0]   state_o,
  output logic         overflow
);

  localparam logic [1:0] ENTER_A = 2'b00;
  localparam logic [1:0] ENTER_B = 2'b01;
  localparam logic [1:0] VALID   = 2'b10;

  // Operand width must hold at least one full switch value.
  if (W < N) begin : g_width_check
    $error("operand_entry: W must be >= N");
  end

  logic           load_prev;
  logic           next_prev;
  logic           load_ev;
  logic           next_ev;
  logic [W-1:0]   target;
  logic [W+N-1:0] appended;
  logic [W-1:0]   ext_val;
  logic [W-1:0]   new_val;
  logic           spill;
  logic [1:0]     state_n;
  logic [W-1:0]   operand_a_n;
  logic [W-1:0]   operand_b_n;
  logic           overflow_n;

  // Rising-edge events; prev regs reset high so a held button yields nothing.
  assign load_ev = load_btn & ~load_prev;
  assign next_ev = next_btn & ~next_prev;

  // Value a load event would write into the operand of the current state.
  // The concatenation performs the shift: its low W bits are the appended
  // value and its top N bits are exactly the bits pushed out of the target.
  always_comb begin
    target   = (state_o == ENTER_B) ? operand_b : operand_a;
    appended = {target, switch_in};
    if (SIGNED != 0) begin
      ext_val = W'($signed(switch_in));
    end else begin
      ext_val = W'(switch_in);
    end
    if (append_mode) begin
      new_val = appended[W-1:0];
      spill   = |appended[W+N-1:W];
    end else begin
      new_val = ext_val;
      spill   = 1'b0;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_n     = state_o;
    operand_a_n = operand_a;
    operand_b_n = operand_b;
    overflow_n  = overflow;
    if (clear) begin
      state_n     = ENTER_A;
      operand_a_n = '0;
      operand_b_n = '0;
      overflow_n  = 1'b0;
    end else begin
      case (state_o)
        ENTER_A: begin
          if (load_ev) begin
            operand_a_n = new_val;
            overflow_n  = overflow | spill;
          end
          if (next_ev) state_n = ENTER_B;
        end
        ENTER_B: begin
          if (load_ev) begin
            operand_b_n = new_val;
            overflow_n  = overflow | spill;
          end
          if (next_ev) state_n = VALID;
        end
        VALID: begin
          if (out_ready) begin
            state_n    = ENTER_A;
            overflow_n = 1'b0;
          end
        end
        default: state_n = ENTER_A;
      endcase
    end
  end

  // State, operand and flag registers; edge trackers run even during clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_o   <= ENTER_A;
      operand_a <= '0;
      operand_b <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      load_prev <= 1'b1;
      next_prev <= 1'b1;
    end else begin
      state_o   <= state_n;
      operand_a <= operand_a_n;
      operand_b <= operand_b_n;
      overflow  <= overflow_n;
      out_valid <= (state_n == VALID);
      load_prev <= load_btn;
      next_prev <= next_btn;
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry (N=4, W=6). Two instances share all
// inputs: dut0 zero-extends, dut1 sign-extends. Expected results are pushed
// to a scoreboard queue as stimulus is driven and popped after the clock.
module tb_operand_entry;

  logic       clk;
  logic       reset;
  logic [3:0] switch_in;
  logic       load_btn;
  logic       next_btn;
  logic       append_mode;
  logic       clear;
  logic       out_ready;

  logic [5:0] a0, b0, a1, b1;
  logic [1:0] st0, st1;
  logic       v0, v1, ovf0, ovf1;

  int tests;
  int fails;

  typedef struct {
    string      tag;
    int         inst;
    logic [5:0] a;
    logic [5:0] b;
    logic [1:0] st;
    logic       v;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  operand_entry #(.N(4), .W(6), .SIGNED(0)) dut0 (
    .clk(clk), .reset(reset), .switch_in(switch_in), .load_btn(load_btn),
    .next_btn(next_btn), .append_mode(append_mode), .clear(clear),
    .out_ready(out_ready), .operand_a(a0), .operand_b(b0), .out_valid(v0),
    .state_o(st0), .overflow(ovf0)
  );

  operand_entry #(.N(4), .W(6), .SIGNED(1)) dut1 (
    .clk(clk), .reset(reset), .switch_in(switch_in), .load_btn(load_btn),
    .next_btn(next_btn), .append_mode(append_mode), .clear(clear),
    .out_ready(out_ready), .operand_a(a1), .operand_b(b1), .out_valid(v1),
    .state_o(st1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, field, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int inst, input logic [5:0] a,
                      input logic [5:0] b, input logic [1:0] st,
                      input logic v, input logic ovf);
    exp_t e;
    e.tag = tag; e.inst = inst; e.a = a; e.b = b; e.st = st; e.v = v; e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Compare every queued expectation against the current DUT outputs.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.inst == 0) begin
        cmp(e.tag, "a",   8'(a0),   8'(e.a));
        cmp(e.tag, "b",   8'(b0),   8'(e.b));
        cmp(e.tag, "st",  8'(st0),  8'(e.st));
        cmp(e.tag, "v",   8'(v0),   8'(e.v));
        cmp(e.tag, "ovf", 8'(ovf0), 8'(e.ovf));
      end else begin
        cmp(e.tag, "a",   8'(a1),   8'(e.a));
        cmp(e.tag, "b",   8'(b1),   8'(e.b));
        cmp(e.tag, "st",  8'(st1),  8'(e.st));
        cmp(e.tag, "v",   8'(v1),   8'(e.v));
        cmp(e.tag, "ovf", 8'(ovf1), 8'(e.ovf));
      end
    end
  endtask

  task automatic press_load(input logic [3:0] sw);
    switch_in = sw;
    load_btn  = 1'b1;
    tick();
    load_btn  = 1'b0;
    tick();
  endtask

  task automatic press_next();
    next_btn = 1'b1;
    tick();
    next_btn = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    switch_in = '0; load_btn = 0; next_btn = 0;
    append_mode = 0; clear = 0; out_ready = 0;
    tick(); tick();
    push("reset", 0, 6'b0, 6'b0, 2'b00, 0, 0);
    push("reset", 1, 6'b0, 6'b0, 2'b00, 0, 0);
    drain();
    reset = 1'b0;
    tick();

    // Basic entry of a pair; dut1 sign-extends 1010.
    press_load(4'b1010);
    push("load_a", 0, 6'b001010, 6'b0, 2'b00, 0, 0);
    push("load_a_sext", 1, 6'b111010, 6'b0, 2'b00, 0, 0);
    drain();
    press_next();
    press_load(4'b0011);
    press_next();
    push("pair", 0, 6'b001010, 6'b000011, 2'b10, 1, 0);
    push("pair_sext", 1, 6'b111010, 6'b000011, 2'b10, 1, 0);
    drain();

    // Events in VALID are ignored; out_ready completes the handshake.
    press_load(4'b1111);
    press_next();
    push("valid_ignore", 0, 6'b001010, 6'b000011, 2'b10, 1, 0);
    drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push("handshake", 0, 6'b001010, 6'b000011, 2'b00, 0, 0);
    drain();

    // Positive value sign-extends to itself.
    press_load(4'b0101);
    push("load_pos_sext", 1, 6'b000101, 6'b000011, 2'b00, 0, 0);
    drain();

    // Clear, then shift-append into A.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push("clear", 0, 6'b0, 6'b0, 2'b00, 0, 0);
    drain();
    append_mode = 1'b1;
    press_load(4'd3);
    press_load(4'd5);
    push("append_35", 0, 6'b110101, 6'b0, 2'b00, 0, 0);
    push("append_35_s", 1, 6'b110101, 6'b0, 2'b00, 0, 0);
    drain();
    press_load(4'd1);
    push("append_ovf", 0, 6'b010001, 6'b0, 2'b00, 0, 1);
    drain();
    press_next();
    press_load(4'd2);
    push("ovf_sticky", 0, 6'b010001, 6'b000010, 2'b01, 0, 1);
    drain();
    press_next();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push("ovf_cleared", 0, 6'b010001, 6'b000010, 2'b00, 0, 0);
    drain();
    append_mode = 1'b0;

    // Held button: one write only, even as the switches change.
    switch_in = 4'b0111;
    load_btn  = 1'b1;
    tick();
    switch_in = 4'b1001;
    for (int i = 0; i < 9; i++) tick();
    load_btn = 1'b0;
    tick();
    push("held_once", 0, 6'b000111, 6'b000010, 2'b00, 0, 0);
    drain();

    // out_ready outside VALID has no effect.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push("ready_idle", 0, 6'b000111, 6'b000010, 2'b00, 0, 0);
    drain();

    // Button held through reset release produces no event.
    switch_in = 4'b1100;
    load_btn  = 1'b1;
    reset     = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    load_btn = 1'b0;
    tick();
    push("held_reset", 0, 6'b0, 6'b0, 2'b00, 0, 0);
    drain();

    // Clear in ENTER_B with a simultaneous load event.
    press_load(4'b0110);
    press_next();
    push("enter_b", 0, 6'b000110, 6'b0, 2'b01, 0, 0);
    drain();
    switch_in = 4'b1111;
    clear     = 1'b1;
    load_btn  = 1'b1;
    tick();
    clear    = 1'b0;
    load_btn = 1'b0;
    push("clear_load", 0, 6'b0, 6'b0, 2'b00, 0, 0);
    drain();
    tick();
    push("clear_after", 0, 6'b0, 6'b0, 2'b00, 0, 0);
    drain();

    // Simultaneous load and next events.
    switch_in = 4'b0101;
    load_btn  = 1'b1;
    next_btn  = 1'b1;
    tick();
    load_btn = 1'b0;
    next_btn = 1'b0;
    push("load_next", 0, 6'b000101, 6'b0, 2'b01, 0, 0);
    drain();

    // Reset mid-entry aborts.
    press_load(4'b1001);
    reset = 1'b1;
    #1;
    push("reset_mid", 0, 6'b0, 6'b0, 2'b00, 0, 0);
    drain();
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL have parameter N, default 4: switch input width, N >= 1.
REQ-002 The block SHALL have parameter W, default 6: operand width; the block SHALL enforce W >= N at elaboration.
REQ-003 The block SHALL have parameter SIGNED, default 0: 0 zero-extends switch values, 1 sign-extends them.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port switch_in, input, N bits: raw operand value from the switches.
REQ-007 The block SHALL have port load_btn, input, 1 bit: level, synchronous to clk; each rising edge is one capture event.
REQ-008 The block SHALL have port next_btn, input, 1 bit: level; each rising edge advances to the next operand.
REQ-009 The block SHALL have port append_mode, input, 1 bit: 0 selects direct load, 1 selects shift-append.
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous clear.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the operand pair.
REQ-012 The block SHALL have port operand_a, output, W bits: first operand register.
REQ-013 The block SHALL have port operand_b, output, W bits: second operand register.
REQ-014 The block SHALL have port out_valid, output, 1 bit: the operand pair is complete and offered.
REQ-015 The block SHALL have port state_o, output, 2 bits: current state (00 ENTER_A, 01 ENTER_B, 10 VALID).
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky append-overflow flag.

Function
REQ-017 Edge detect: the block SHALL register the previous level of load_btn and next_btn; an event SHALL be btn=1 while prev=0; a held button SHALL yield exactly one event.
REQ-018 Events SHALL take effect at the clock edge where they are detected; register updates SHALL be visible the following cycle (1-cycle latency).
REQ-019 ext(sw) SHALL be switch_in zero-extended to W bits (SIGNED=0) or sign-extended from bit N-1 (SIGNED=1).
REQ-020 Direct load (append_mode=0): the target register SHALL load ext(switch_in).
REQ-021 Shift-append (append_mode=1): target SHALL become (target << N) | switch_in (unextended), truncated to W bits; if W == N, this SHALL equal a direct load.
REQ-022 The block SHALL set overflow in the same update whenever any of the bits shifted out by an append (target[W-1:W-N]) is nonzero; overflow SHALL then hold until cleared.
REQ-023 ENTER_A: a load event SHALL write operand_a; a next event SHALL move to ENTER_B.
REQ-024 ENTER_B: a load event SHALL write operand_b; a next event SHALL move to VALID.
REQ-025 VALID: out_valid=1; load and next events SHALL be ignored; out_ready=1 SHALL complete the handshake, move to ENTER_A, and clear overflow.
REQ-026 Operands SHALL be retained across the handshake until they are overwritten.
REQ-027 out_valid SHALL be 1 only in VALID; out_ready outside VALID SHALL have no effect.
REQ-028 Simultaneous load and next events: the block SHALL apply the load to the current operand and perform the transition in the same cycle.
REQ-029 clear SHALL have priority over all events: operands zeroed, state ENTER_A, overflow 0, out_valid 0; edge registers SHALL keep tracking, and events in the clear cycle SHALL be discarded.
REQ-030 State encoding 11 SHALL be unreachable; if it is entered, the block SHALL return to ENTER_A on the next clock.

Reset
REQ-031 On reset, operand_a, operand_b, overflow and out_valid SHALL be 0, and state SHALL be ENTER_A.
REQ-032 On reset, both edge-detect prev registers SHALL be set to 1, so a button held through reset release SHALL produce no event.
REQ-033 Reset asserted mid-entry or in VALID SHALL abort immediately, with no handshake and no event completion.

Verification (N=4, W=6)
REQ-034 The bench SHALL cover: SIGNED=0, sw=1010, load; next; sw=0011, load; next -> A=001010, B=000011, out_valid=1, state_o=10.
REQ-035 The bench SHALL cover: SIGNED=1, sw=1010, load -> A=111010; sw=0101, load -> A=000101.
REQ-036 The bench SHALL cover: append_mode=1 from A=0, sw=3 then 5 -> A=110101, overflow=0; then sw=1 -> A=010001, overflow=1.
REQ-037 The bench SHALL cover: load_btn held high 10 cycles -> exactly one write; load_btn held through reset release -> no write.
REQ-038 The bench SHALL cover: in VALID, load and next pulses -> no change; out_ready=1 -> state 00, out_valid=0, overflow=0, A and B unchanged.
REQ-039 The bench SHALL cover: clear in ENTER_B with a simultaneous load event -> A=B=0, state 00, no write.
